// File: rtl/hidden_layer_if.sv
// Handshake and weight-load bundle for the time-multiplexed hidden layer.
// The master side feeds input vectors and weights; the slave side is the layer itself.
interface hidden_layer_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int IN_W    = 5,
    parameter int W_W     = 5,
    parameter int OUT_W   = 12
);
    localparam int NUM_W = NUM_IN * NUM_OUT;
    localparam int AW    = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_IN*IN_W-1:0]      in_data;
    logic                        w_we;
    logic [AW-1:0]               w_addr;
    logic signed [W_W-1:0]       w_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_OUT*OUT_W-1:0]    out_data;
    logic                        busy;

    modport master (
        output in_valid, in_data, w_we, w_addr, w_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, w_we, w_addr, w_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/hidden_layer_seq.sv
// Time-multiplexed dense hidden layer: one shared signed MAC walks NUM_OUT neurons
// over NUM_IN inputs, with a loadable weight file and saturating (optionally ReLU) outputs.
module hidden_layer_seq #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int IN_W    = 5,
    parameter int W_W     = 5,
    parameter int OUT_W   = 12,
    parameter bit RELU    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    hidden_layer_if.slave   bus
);
    localparam int NUM_W = NUM_IN * NUM_OUT;
    localparam int AW    = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int OW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int PW    = IN_W + W_W;
    localparam int ACC_W = PW + $clog2(NUM_IN) + 1;
    localparam int SW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_IN*IN_W-1:0]      in_q, in_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [IW-1:0]               i_q, i_d;
    logic [OW-1:0]               o_q, o_d;
    logic [NUM_OUT*OUT_W-1:0]    out_q, out_d;
    logic signed [W_W-1:0]       w_q [NUM_W];
    logic signed [W_W-1:0]       w_d [NUM_W];

    logic [AW-1:0]               w_idx;
    logic signed [IN_W-1:0]      x_cur;
    logic signed [W_W-1:0]       w_cur;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_W-1:0]     acc_sum;

    // Clamp to the OUT_W range first, then optionally drop negatives.
    function automatic logic signed [OUT_W-1:0] sat_act(input logic signed [ACC_W-1:0] v);
        logic signed [SW-1:0]    x;
        logic signed [SW-1:0]    hi;
        logic signed [SW-1:0]    lo;
        logic signed [OUT_W-1:0] r;
        x  = {{(SW-ACC_W){v[ACC_W-1]}}, v};
        hi = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (x > hi) begin
            r = hi[OUT_W-1:0];
        end else if (x < lo) begin
            r = lo[OUT_W-1:0];
        end else begin
            r = x[OUT_W-1:0];
        end
        if (RELU && r[OUT_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // Operands are sign-extended to the full product width, so the low PW bits are exact.
    always_comb begin
        w_idx   = AW'(int'(o_q) * NUM_IN + int'(i_q));
        x_cur   = in_q[int'(i_q)*IN_W +: IN_W];
        w_cur   = w_q[w_idx];
        prod    = {{W_W{x_cur[IN_W-1]}}, x_cur} * {{IN_W{w_cur[W_W-1]}}, w_cur};
        acc_sum = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        acc_d   = acc_q;
        i_d     = i_q;
        o_d     = o_q;
        out_d   = out_q;
        w_d     = w_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    in_d    = bus.in_data;
                    acc_d   = '0;
                    i_d     = '0;
                    o_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (i_q == IW'(NUM_IN - 1)) begin
                    out_d[int'(o_q)*OUT_W +: OUT_W] = sat_act(acc_sum);
                    acc_d = '0;
                    i_d   = '0;
                    if (o_q == OW'(NUM_OUT - 1)) begin
                        o_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        o_d = o_q + OW'(1);
                    end
                end else begin
                    acc_d = acc_sum;
                    i_d   = i_q + IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Weights are frozen outside IDLE so a running computation sees one consistent set.
        if (bus.w_we && (state_q == S_IDLE) && (int'(bus.w_addr) < NUM_W)) begin
            w_d[bus.w_addr] = bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            o_q     <= '0;
            out_q   <= '0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            o_q     <= o_d;
            out_q   <= out_d;
            w_q     <= w_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_hidden_layer_seq.sv
// Scoreboard bench for hidden_layer_seq: two instances (12-bit ReLU, 8-bit linear) share stimulus;
// expected vectors come from an integer dot-product model and are checked by an independent monitor.
module tb_hidden_layer_seq;
    localparam int NI = 4;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hidden_layer_if #(.NUM_IN(4), .NUM_OUT(4), .IN_W(5), .W_W(5), .OUT_W(12)) ifa ();
    hidden_layer_if #(.NUM_IN(4), .NUM_OUT(4), .IN_W(5), .W_W(5), .OUT_W(8))  ifb ();

    hidden_layer_seq #(.NUM_IN(4), .NUM_OUT(4), .IN_W(5), .W_W(5), .OUT_W(12), .RELU(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    hidden_layer_seq #(.NUM_IN(4), .NUM_OUT(4), .IN_W(5), .W_W(5), .OUT_W(8), .RELU(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.w_we      = ifa.w_we;
    assign ifb.w_addr    = ifa.w_addr;
    assign ifb.w_data    = ifa.w_data;
    assign ifb.out_ready = ifa.out_ready;

    typedef struct {
        logic [47:0] a;
        logic [31:0] b;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   w_m[NI*NO];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int s, input int w, input bit relu);
        int hi;
        int lo;
        int r;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        r  = s;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    // Plain dot product per neuron, then range-limit for each instance's output format.
    function automatic void predict(input logic [19:0] v, output logic [47:0] ea, output logic [31:0] eb);
        ea = '0;
        eb = '0;
        for (int o = 0; o < NO; o++) begin
            int s;
            s = 0;
            for (int i = 0; i < NI; i++) begin
                int xi;
                xi = $signed(v[i*5 +: 5]);
                s += xi * w_m[o*NI + i];
            end
            ea[o*12 +: 12] = 12'(clamp(s, 12, 1'b1));
            eb[o*8 +: 8]   = 8'(clamp(s, 8, 1'b0));
        end
    endfunction

    function automatic logic [19:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
    endfunction

    function automatic int rnd5();
        return int'($urandom_range(0, 31)) - 16;
    endfunction

    task automatic wr(input int addr, input int val);
        @(negedge clk);
        ifa.w_we   = 1'b1;
        ifa.w_addr = 4'(addr);
        ifa.w_data = 5'(val);
        if (!ifa.busy) w_m[addr] = val;
        @(negedge clk);
        ifa.w_we = 1'b0;
    endtask

    task automatic wr_all(input int val);
        for (int k = 0; k < NI*NO; k++) wr(k, val);
    endtask

    task automatic wr_rand();
        for (int k = 0; k < NI*NO; k++) wr(k, rnd5());
    endtask

    task automatic send(input logic [19:0] v);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        ifa.in_valid = 1'b1;
        ifa.in_data  = v;
        while (!ifa.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ifa.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", ifa.in_ready);
            ifa.in_valid = 1'b0;
            return;
        end
        predict(v, e.a, e.b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        ifa.in_valid = 1'b0;
    endtask

    task automatic drain(input int hold);
        int t;
        t = 0;
        while (!ifa.out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!ifa.out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: out_valid stayed %0b, expected 1", ifa.out_valid);
            return;
        end
        repeat (hold) @(negedge clk);
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
        check("in_ready_after_hs", ifa.in_ready, 1);
        check("out_valid_after_hs", ifa.out_valid, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        prev_v;
        logic [47:0] last_a;
        logic [31:0] last_b;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (ifa.out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: out_data=%0h with empty scoreboard", ifa.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data_a", ifa.out_data, e.a);
                    check("out_data_b", ifb.out_data, e.b);
                    check("latency", 64'(cyc - e.acc), 64'(NI*NO));
                    check("out_valid_b", ifb.out_valid, 1);
                end
            end else if (ifa.out_valid && prev_v) begin
                check("hold_data_a", ifa.out_data, last_a);
                check("hold_data_b", ifb.out_data, last_b);
                check("hold_in_ready", ifa.in_ready, 0);
            end
            prev_v = ifa.out_valid;
            last_a = ifa.out_data;
            last_b = ifb.out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [19:0] v;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.w_we      = 1'b0;
        ifa.w_addr    = '0;
        ifa.w_data    = '0;
        ifa.out_ready = 1'b0;
        for (int k = 0; k < NI*NO; k++) w_m[k] = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", ifa.in_ready, 1);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_out_data_a", ifa.out_data, 0);
        check("rst_out_data_b", ifb.out_data, 0);
        rst_n = 1'b1;

        // Unit weights: every neuron sums the inputs.
        wr_all(1);
        send(pack4(1, 2, 3, 4));
        drain(0);

        // Neuron 1 negated: ReLU instance clips to 0, linear instance shows -10.
        for (int i = 0; i < NI; i++) wr(NI + i, -1);
        send(pack4(1, 2, 3, 4));
        drain(0);

        // Extremes: +1024 and -960 exercise both 8-bit saturation rails.
        wr_all(-16);
        send(pack4(-16, -16, -16, -16));
        drain(0);
        wr_all(15);
        send(pack4(-16, -16, -16, -16));
        drain(0);

        // Backpressure in DONE.
        wr_rand();
        send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
        drain(5);
        send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
        drain(0);

        // Writes while busy must be dropped.
        wr_rand();
        v = pack4(rnd5(), rnd5(), rnd5(), rnd5());
        send(v);
        repeat (3) @(negedge clk);
        wr(0, (w_m[0] == 7) ? -7 : 7);
        wr(5, (w_m[5] == 3) ? -3 : 3);
        drain(0);
        send(v);
        drain(0);

        // Reset in the middle of a MAC sequence.
        send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", ifa.out_valid, 0);
        check("mid_rst_in_ready", ifa.in_ready, 1);
        check("mid_rst_busy", ifa.busy, 0);
        check("mid_rst_out_data_a", ifa.out_data, 0);
        check("mid_rst_out_data_b", ifb.out_data, 0);
        sb.delete();
        for (int k = 0; k < NI*NO; k++) w_m[k] = 0;
        @(negedge clk);
        check("mid_rst_in_ready_edge", ifa.in_ready, 1);
        rst_n = 1'b1;
        send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
        drain(0);
        wr_rand();
        send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
        drain(1);

        // Random weights, vectors and backpressure.
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) wr_rand();
            else wr(int'($urandom_range(0, 15)), rnd5());
            send(pack4(rnd5(), rnd5(), rnd5(), rnd5()));
            drain(int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
